decode_issue_ctrl: RTL and testbench



---
 rtl/decode_issue_ctrl_pkg.sv | 18 +
 rtl/decode_issue_ctrl_reg_scoreboard.sv | 46 ++++
 rtl/decode_issue_ctrl.sv | 111 +++++++++++
 tb/tb_decode_issue_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types and constants for the Frost32 decode/issue controller.
package PkgDecodeIssueCtrl;

   localparam int REG_COUNT = 16;
   localparam int REG_IDX_W = $clog2(REG_COUNT);

   localparam logic [1:0] GRP_ALU    = 2'd0;
   localparam logic [1:0] GRP_BRANCH = 2'd1;
   localparam logic [1:0] GRP_CALL   = 2'd2;
   localparam logic [1:0] GRP_MEM    = 2'd3;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      WAIT_CTRL = 2'd1,
      WAIT_MEM  = 2'd2
   } state_t;

endpackage

// File: rtl/decode_issue_ctrl_reg_scoreboard.sv
// Pending-load register scoreboard with three busy lookup ports.
// r0 is never busy; a set wins over a clear of the same register.
module reg_scoreboard
   import PkgDecodeIssueCtrl::*;
#(
   parameter int N = REG_COUNT,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         set_en,
   input  logic [W-1:0] set_idx,
   input  logic         clr_en,
   input  logic [W-1:0] clr_idx,
   input  logic [W-1:0] rd0_idx,
   input  logic [W-1:0] rd1_idx,
   input  logic [W-1:0] rd2_idx,
   output logic         rd0_busy,
   output logic         rd1_busy,
   output logic         rd2_busy,
   output logic [N-1:0] busy
);

   logic [N-1:0] busy_nxt;

   always_comb begin
      busy_nxt = busy;
      if (clr_en && clr_idx != '0)
         busy_nxt[clr_idx] = 1'b0;
      if (set_en && set_idx != '0)
         busy_nxt[set_idx] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   assign rd0_busy = (rd0_idx != '0) && busy[rd0_idx];
   assign rd1_busy = (rd1_idx != '0) && busy[rd1_idx];
   assign rd2_busy = (rd2_idx != '0) && busy[rd2_idx];

endmodule

// File: rtl/decode_issue_ctrl.sv
// Issue controller between decode and execute.
// DECODE_ISSUE_PERF_CNT_EN adds saturating stall counters.
module decode_issue_ctrl
   import PkgDecodeIssueCtrl::*;
#(
   parameter int NUM_REGS       = REG_COUNT,
   parameter int PERF_CNT_WIDTH = 32,
   localparam int IW = $clog2(NUM_REGS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                dec_group,
   input  logic [IW-1:0]             dec_ra_index,
   input  logic [IW-1:0]             dec_rb_index,
   input  logic [IW-1:0]             dec_rc_index,
   input  logic                      dec_causes_stall,
   input  logic                      dec_is_load,
   input  logic                      dec_is_store,
   output logic                      out_valid,
   input  logic                      out_ready,
   input  logic                      ctrl_done,
   input  logic                      mem_done,
   input  logic                      flush,
   input  logic                      ld_wb_valid,
   input  logic [IW-1:0]             ld_wb_index,
`ifdef DECODE_ISSUE_PERF_CNT_EN
   output logic [PERF_CNT_WIDTH-1:0] stall_ctrl_cycles,
   output logic [PERF_CNT_WIDTH-1:0] stall_mem_cycles,
   output logic [PERF_CNT_WIDTH-1:0] stall_raw_cycles,
`endif
   output logic [NUM_REGS-1:0]       busy_regs
);

   state_t state;
   logic   issue;
   logic   hazard;
   logic   use_ra;
   logic   ra_busy;
   logic   rb_busy;
   logic   rc_busy;

   reg_scoreboard #(.N(NUM_REGS)) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue && dec_is_load),
      .set_idx  (dec_ra_index),
      .clr_en   (ld_wb_valid),
      .clr_idx  (ld_wb_index),
      .rd0_idx  (dec_ra_index),
      .rd1_idx  (dec_rb_index),
      .rd2_idx  (dec_rc_index),
      .rd0_busy (ra_busy),
      .rd1_busy (rb_busy),
      .rd2_busy (rc_busy),
      .busy     (busy_regs)
   );

   // rA is only read by conditional branches and stores
   assign use_ra = (dec_group == GRP_BRANCH) || dec_is_store;
   assign hazard = in_valid
                && (rb_busy || rc_busy || (use_ra && ra_busy));

   assign out_valid = rst_n && in_valid && state == RUN
                   && !hazard && !flush;
   assign in_ready  = out_valid && out_ready;
   assign issue     = in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
      end else if (flush) begin
         state <= RUN;
      end else begin
         unique case (state)
            RUN: begin
               if (issue && dec_causes_stall) begin
                  if (dec_group == GRP_MEM)
                     state <= WAIT_MEM;
                  else if (dec_group != GRP_ALU)
                     state <= WAIT_CTRL;
               end
            end
            WAIT_CTRL: if (ctrl_done) state <= RUN;
            WAIT_MEM:  if (mem_done)  state <= RUN;
            default:   state <= RUN;
         endcase
      end
   end

`ifdef DECODE_ISSUE_PERF_CNT_EN
   localparam logic [PERF_CNT_WIDTH-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_ctrl_cycles <= '0;
         stall_mem_cycles  <= '0;
         stall_raw_cycles  <= '0;
      end else begin
         if (state == WAIT_CTRL && stall_ctrl_cycles != CNT_MAX)
            stall_ctrl_cycles <= stall_ctrl_cycles + 1'b1;
         if (state == WAIT_MEM && stall_mem_cycles != CNT_MAX)
            stall_mem_cycles <= stall_mem_cycles + 1'b1;
         if (state == RUN && hazard && stall_raw_cycles != CNT_MAX)
            stall_raw_cycles <= stall_raw_cycles + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed vector bench for decode_issue_ctrl.
module tb_decode_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  dec_group = '0;
   logic [3:0]  dec_ra_index = '0;
   logic [3:0]  dec_rb_index = '0;
   logic [3:0]  dec_rc_index = '0;
   logic        dec_causes_stall = 1'b0;
   logic        dec_is_load = 1'b0;
   logic        dec_is_store = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        ctrl_done = 1'b0;
   logic        mem_done = 1'b0;
   logic        flush = 1'b0;
   logic        ld_wb_valid = 1'b0;
   logic [3:0]  ld_wb_index = '0;
   logic [15:0] busy_regs;
`ifdef DECODE_ISSUE_PERF_CNT_EN
   logic [31:0] stall_ctrl_cycles;
   logic [31:0] stall_mem_cycles;
   logic [31:0] stall_raw_cycles;
   logic [31:0] raw_snap;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   decode_issue_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .dec_group        (dec_group),
      .dec_ra_index     (dec_ra_index),
      .dec_rb_index     (dec_rb_index),
      .dec_rc_index     (dec_rc_index),
      .dec_causes_stall (dec_causes_stall),
      .dec_is_load      (dec_is_load),
      .dec_is_store     (dec_is_store),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .ctrl_done        (ctrl_done),
      .mem_done         (mem_done),
      .flush            (flush),
      .ld_wb_valid      (ld_wb_valid),
      .ld_wb_index      (ld_wb_index),
`ifdef DECODE_ISSUE_PERF_CNT_EN
      .stall_ctrl_cycles(stall_ctrl_cycles),
      .stall_mem_cycles (stall_mem_cycles),
      .stall_raw_cycles (stall_raw_cycles),
`endif
      .busy_regs        (busy_regs)
   );

   typedef struct {
      logic        rst;
      logic        iv;
      logic [1:0]  grp;
      logic [3:0]  ra, rb, rc;
      logic        st, ld, sto, ordy, cd, md, fl, wbv;
      logic [3:0]  wbi;
      logic        eov, eir;
      logic [15:0] ebusy;
   } vec_t;

   localparam int NV = 37;
   vec_t tbl [NV];

   function automatic vec_t mk(
      input logic rst, iv, input logic [1:0] grp,
      input logic [3:0] ra, rb, rc,
      input logic st, ld, sto, ordy, cd, md, fl, wbv,
      input logic [3:0] wbi,
      input logic eov, eir, input logic [15:0] ebusy);
      vec_t v;
      v.rst = rst; v.iv = iv; v.grp = grp;
      v.ra = ra; v.rb = rb; v.rc = rc;
      v.st = st; v.ld = ld; v.sto = sto; v.ordy = ordy;
      v.cd = cd; v.md = md; v.fl = fl; v.wbv = wbv;
      v.wbi = wbi; v.eov = eov; v.eir = eir; v.ebusy = ebusy;
      return v;
   endfunction

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h",
                  name, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      rst_n = v.rst; in_valid = v.iv; dec_group = v.grp;
      dec_ra_index = v.ra; dec_rb_index = v.rb; dec_rc_index = v.rc;
      dec_causes_stall = v.st; dec_is_load = v.ld;
      dec_is_store = v.sto; out_ready = v.ordy;
      ctrl_done = v.cd; mem_done = v.md; flush = v.fl;
      ld_wb_valid = v.wbv; ld_wb_index = v.wbi;
   endtask

   initial begin
      // reset held with a valid instruction present
      tbl[0]  = mk(0,1,0,0,0,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0000);
      tbl[1]  = mk(0,1,0,0,0,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0000);
      tbl[2]  = mk(1,1,0,0,0,0, 0,0,0,1,0,0,0,0,0, 1,1,16'h0000);
      // stalling branch, three blocked cycles, ctrl_done in the third
      tbl[3]  = mk(1,1,1,1,2,3, 1,0,0,1,0,0,0,0,0, 1,1,16'h0000);
      tbl[4]  = mk(1,1,0,0,0,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0000);
      tbl[5]  = mk(1,1,0,0,0,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0000);
      tbl[6]  = mk(1,1,0,0,0,0, 0,0,0,1,1,0,0,0,0, 0,0,16'h0000);
      tbl[7]  = mk(1,1,0,0,0,0, 0,0,0,1,0,0,0,0,0, 1,1,16'h0000);
      tbl[8]  = mk(1,1,0,0,0,0, 0,0,0,0,0,0,0,0,0, 1,0,16'h0000);
      // load r5, RAW on rB, writeback releases next cycle
      tbl[9]  = mk(1,1,3,5,1,2, 0,1,0,1,0,0,0,0,0, 1,1,16'h0000);
      tbl[10] = mk(1,1,0,0,5,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0020);
      tbl[11] = mk(1,1,0,0,5,0, 0,0,0,1,0,0,0,1,5, 0,0,16'h0020);
      tbl[12] = mk(1,1,0,0,5,0, 0,0,0,1,0,0,0,0,0, 1,1,16'h0000);
      // load to r0 never marks busy
      tbl[13] = mk(1,1,3,0,0,0, 0,1,0,1,0,0,0,0,0, 1,1,16'h0000);
      tbl[14] = mk(1,1,0,0,0,0, 0,0,0,1,0,0,0,0,0, 1,1,16'h0000);
      // rA is a source only for stores and group 1
      tbl[15] = mk(1,1,3,3,0,0, 0,1,0,1,0,0,0,0,0, 1,1,16'h0000);
      tbl[16] = mk(1,1,3,3,0,0, 0,0,1,1,0,0,0,0,0, 0,0,16'h0008);
      tbl[17] = mk(1,1,0,3,0,0, 0,0,0,1,0,0,0,0,0, 1,1,16'h0008);
      tbl[18] = mk(1,1,1,3,0,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0008);
      tbl[19] = mk(1,0,0,0,0,0, 0,0,0,1,0,0,0,1,3, 0,0,16'h0008);
      tbl[20] = mk(1,0,0,0,0,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0000);
      // stalling load r4, flush+mem_done together
      tbl[21] = mk(1,1,3,4,0,0, 1,1,0,1,0,0,0,0,0, 1,1,16'h0000);
      tbl[22] = mk(1,1,0,0,0,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0010);
      tbl[23] = mk(1,1,0,0,0,0, 0,0,0,1,0,1,1,0,0, 0,0,16'h0010);
      tbl[24] = mk(1,1,0,0,0,0, 0,0,0,1,0,0,0,0,0, 1,1,16'h0010);
      tbl[25] = mk(1,1,0,0,0,0, 0,0,0,1,0,0,1,0,0, 0,0,16'h0010);
      // same-cycle writeback and new load of r7
      tbl[26] = mk(1,1,3,7,0,0, 0,1,0,1,0,0,0,0,0, 1,1,16'h0010);
      tbl[27] = mk(1,1,3,7,0,0, 0,1,0,1,0,0,0,1,7, 1,1,16'h0090);
      tbl[28] = mk(1,0,0,0,0,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0090);
      tbl[29] = mk(1,1,0,0,7,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0090);
      tbl[30] = mk(1,1,0,0,7,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0090);
      tbl[31] = mk(1,1,0,0,7,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0090);
      tbl[32] = mk(1,1,0,0,7,0, 0,0,0,1,0,0,0,1,7, 0,0,16'h0090);
      tbl[33] = mk(1,1,0,0,7,0, 0,0,0,1,0,0,0,0,0, 1,1,16'h0010);
      // reset in the middle of a WAIT_CTRL
      tbl[34] = mk(1,1,1,0,0,0, 1,0,0,1,0,0,0,0,0, 1,1,16'h0010);
      tbl[35] = mk(0,1,0,0,0,0, 0,0,0,1,0,0,0,0,0, 0,0,16'h0010);
      tbl[36] = mk(1,1,0,0,0,0, 0,0,0,1,0,0,0,0,0, 1,1,16'h0000);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         apply(tbl[i]);
         #1;
         chk("out_valid", i, 32'(out_valid), 32'(tbl[i].eov));
         chk("in_ready", i, 32'(in_ready), 32'(tbl[i].eir));
         chk("busy_regs", i, 32'(busy_regs), 32'(tbl[i].ebusy));
`ifdef DECODE_ISSUE_PERF_CNT_EN
         if (i == 29) raw_snap = stall_raw_cycles;
         if (i == 32) begin
            chk("stall_raw_delta", i, stall_raw_cycles - raw_snap, 32'd3);
            chk("stall_raw_total", i, stall_raw_cycles, 32'd7);
            chk("stall_ctrl", i, stall_ctrl_cycles, 32'd3);
            chk("stall_mem", i, stall_mem_cycles, 32'd2);
         end
         if (i == 36) chk("stall_raw_rst", i, stall_raw_cycles, 32'd0);
`endif
      end

      // stalling call; mem_done is ignored while waiting on ctrl
      @(negedge clk);
      apply(mk(1,1,2,0,0,0, 1,0,0,1,0,0,0,0,0, 0,0,0));
      #1 chk("call_issue", 100, 32'(out_valid), 32'd1);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         apply(mk(1,1,0,0,0,0, 0,0,0,1,0,1,0,0,0, 0,0,0));
         #1 chk("call_wait", 101 + k, 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      apply(mk(1,1,0,0,0,0, 0,0,0,1,1,0,0,0,0, 0,0,0));
      #1 chk("call_done", 103, 32'(out_valid), 32'd0);
      @(negedge clk);
      apply(mk(1,1,0,0,0,0, 0,0,0,1,0,0,0,0,0, 0,0,0));
      #1 chk("call_resume", 104, 32'(in_ready), 32'd1);
      @(negedge clk);
      apply(mk(1,0,0,0,0,0, 0,0,0,1,0,0,0,0,0, 0,0,0));
      #1 chk("idle", 105, 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
